// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO responder.
//   - Address constants for the PWM duty word and the micros/millis timers.
//   - funct3_e: RISC-V style access size/sign codes.
//   - is_misaligned(): alignment check for an access size and byte lane.
//   - load_extract(): picks the addressed byte/half/word and extends it.
`timescale 1ns/1ps
package mmio_pkg;

  localparam logic [31:0] DUTY_ADDR   = 32'hFFFF_FFFC;
  localparam logic [31:0] MICROS_ADDR = 32'hFFFF_FFF8;
  localparam logic [31:0] MILLIS_ADDR = 32'hFFFF_FFF4;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  // Halves must sit on an even byte, words on a multiple of four.
  // Bytes and undefined codes are never flagged.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_H, F3_HU: return lane[0];
      F3_W:        return lane != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Right-aligns the addressed lane(s) of a word and extends per access code.
  // Undefined codes read as zero.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0, h};
      F3_W:    return word;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mmio_pwm8.sv
// pwm8: one PWM channel. Compares a shared free-running 8-bit counter
// against this channel's duty byte.
//   count  in  8  shared PWM counter
//   duty   in  8  duty byte (0 = always low, 255 = high 255 of 256 cycles)
//   pwm    out 1  active-high PWM output
`timescale 1ns/1ps
module pwm8 (
  input  logic [7:0] count,
  input  logic [7:0] duty,
  output logic       pwm
);

  // Combinational compare so a new duty byte acts on the very next cycle.
  assign pwm = count < duty;

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped peripheral block holding a 4-channel PWM duty
// word plus free-running microsecond and millisecond counters.
//   clk            in   1   sole clock, rising edge
//   reset          in   1   synchronous active-high reset
//   funct3         in   3   access size/sign code
//   dmem_wren      in   1   store strobe
//   dmem_address   in   32  byte address
//   dmem_data_in   in   32  right-aligned store data
//   dmem_data_out  out  32  registered, extended load data
//   misaligned     out  1   one-cycle misaligned-access pulse
//   led/red/green/blue out 1 each  active-high PWM outputs
`timescale 1ns/1ps
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int CLK_HZ = 12000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  funct3,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  output logic [31:0] dmem_data_out,
  output logic        misaligned,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int US_DIV = CLK_HZ / 1000000;
  localparam int MS_DIV = CLK_HZ / 1000;

  logic [7:0]  duty_reg  [4];
  logic [7:0]  duty_next [4];
  logic [7:0]  pwm_cnt_reg;
  logic [31:0] us_pre_reg;
  logic [31:0] ms_pre_reg;
  logic [31:0] micros_reg;
  logic [31:0] millis_reg;
  logic [31:0] data_out_reg;
  logic        misaligned_reg;

  logic [1:0]  lane;
  logic        mis;
  logic        duty_hit;
  logic        store_en;
  logic [31:0] read_word;
  logic [3:0]  pwm_out;
  logic        us_tick;
  logic        ms_tick;

  assign lane     = dmem_address[1:0];
  assign mis      = is_misaligned(funct3, lane);
  assign duty_hit = dmem_address[31:2] == DUTY_ADDR[31:2];
  // Only the duty word is writable; timer words silently drop stores.
  assign store_en = dmem_wren && duty_hit && !mis;

  always_comb begin
    read_word = 32'h0;
    if (duty_hit)
      read_word = {duty_reg[3], duty_reg[2], duty_reg[1], duty_reg[0]};
    else if (dmem_address[31:2] == MICROS_ADDR[31:2])
      read_word = micros_reg;
    else if (dmem_address[31:2] == MILLIS_ADDR[31:2])
      read_word = millis_reg;
  end

  // Per-lane write enable and data; lane 0 = blue ... lane 3 = led.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       we;
      logic [7:0] wdata;

      always_comb begin
        we    = 1'b0;
        wdata = dmem_data_in[8*gi +: 8];
        case (funct3)
          F3_B: begin
            we    = lane == 2'(gi);
            wdata = dmem_data_in[7:0];
          end
          F3_H: begin
            we    = lane[1] == 1'(gi / 2);
            wdata = dmem_data_in[8*(gi % 2) +: 8];
          end
          F3_W:    we = 1'b1;
          default: we = 1'b0;
        endcase
      end

      assign duty_next[gi] = (store_en && we) ? wdata : duty_reg[gi];

      pwm8 u_pwm (
        .count (pwm_cnt_reg),
        .duty  (duty_reg[gi]),
        .pwm   (pwm_out[gi])
      );
    end
  endgenerate

  assign us_tick = us_pre_reg == 32'(US_DIV - 1);
  assign ms_tick = ms_pre_reg == 32'(MS_DIV - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) duty_reg[i] <= 8'h0;
      pwm_cnt_reg    <= 8'h0;
      us_pre_reg     <= 32'h0;
      ms_pre_reg     <= 32'h0;
      micros_reg     <= 32'h0;
      millis_reg     <= 32'h0;
      data_out_reg   <= 32'h0;
      misaligned_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) duty_reg[i] <= duty_next[i];
      pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
      us_pre_reg  <= us_tick ? 32'h0 : us_pre_reg + 32'd1;
      ms_pre_reg  <= ms_tick ? 32'h0 : ms_pre_reg + 32'd1;
      if (us_tick) micros_reg <= micros_reg + 32'd1;
      if (ms_tick) millis_reg <= millis_reg + 32'd1;
      // read_word is the pre-store, pre-increment value of this cycle.
      data_out_reg   <= mis ? 32'h0 : load_extract(read_word, funct3, lane);
      misaligned_reg <= mis;
    end
  end

  assign dmem_data_out = data_out_reg;
  assign misaligned    = misaligned_reg;
  assign blue          = pwm_out[0];
  assign green         = pwm_out[1];
  assign red           = pwm_out[2];
  assign led           = pwm_out[3];

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed self-checking bench for mmio_responder.
`timescale 1ns/1ps
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  funct3;
  logic        dmem_wren;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic [31:0] dmem_data_out;
  logic        misaligned;
  logic        led, red, green, blue;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                         LBU = 3'b100, LHU = 3'b101, BAD = 3'b011;

  mmio_responder #(.CLK_HZ(12000000)) dut (
    .clk           (clk),
    .reset         (reset),
    .funct3        (funct3),
    .dmem_wren     (dmem_wren),
    .dmem_address  (dmem_address),
    .dmem_data_in  (dmem_data_in),
    .dmem_data_out (dmem_data_out),
    .misaligned    (misaligned),
    .led           (led),
    .red           (red),
    .green         (green),
    .blue          (blue)
  );

  always #5 clk = ~clk;

  // Present one access for one cycle, then return 1ns after the edge.
  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    dmem_wren = we; funct3 = f3; dmem_address = a; dmem_data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, LW, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    drive(1'b1, LW, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    vectors++;
    if (dmem_data_out !== 32'h0 || misaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: data=%h mis=%b required data=00000000 mis=0", dmem_data_out, misaligned);
    end
    vectors++;
    if ({led, red, green, blue} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_pwm: got %b required 0000", {led, red, green, blue});
    end
    reset = 1'b0;
    drive(1'b0, LW, 32'hFFFF_FFFC, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_store_discard: got %h required 00000000", dmem_data_out);
    end
    $display("test_reset: done");
  endtask

  task automatic test_pwm();
    int nb, ng, nr, nl;
    drive(1'b1, LW, 32'hFFFF_FFFC, 32'h80FF_0040);
    dmem_wren = 1'b0; dmem_address = 32'h0;
    nb = 0; ng = 0; nr = 0; nl = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      nb += int'(blue); ng += int'(green); nr += int'(red); nl += int'(led);
    end
    vectors++;
    if (nb != 64) begin miscompares++; $display("FAIL pwm_blue_count: got %0d required 64", nb); end
    vectors++;
    if (ng != 0) begin miscompares++; $display("FAIL pwm_green_count: got %0d required 0", ng); end
    vectors++;
    if (nr != 255) begin miscompares++; $display("FAIL pwm_red_count: got %0d required 255", nr); end
    vectors++;
    if (nl != 128) begin miscompares++; $display("FAIL pwm_led_count: got %0d required 128", nl); end
    @(posedge clk); #1;
    drive(1'b0, LW, 32'hFFFF_FFFC, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'h80FF_0040) begin
      miscompares++;
      $display("FAIL pwm_word_readback: got %h required 80ff0040", dmem_data_out);
    end
    $display("test_pwm: blue=%0d green=%0d red=%0d led=%0d", nb, ng, nr, nl);
  endtask

  task automatic test_byte_half();
    drive(1'b1, LB, 32'hFFFF_FFFE, 32'h0000_007F);
    drive(1'b0, LB, 32'hFFFF_FFFE, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'h0000_007F) begin
      miscompares++; $display("FAIL lb_positive: got %h required 0000007f", dmem_data_out);
    end
    drive(1'b1, LB, 32'hFFFF_FFFE, 32'hABCD_EF90);
    drive(1'b0, LB, 32'hFFFF_FFFE, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'hFFFF_FF90) begin
      miscompares++; $display("FAIL lb_negative: got %h required ffffff90", dmem_data_out);
    end
    drive(1'b0, LBU, 32'hFFFF_FFFE, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'h0000_0090) begin
      miscompares++; $display("FAIL lbu: got %h required 00000090", dmem_data_out);
    end
    // Word is now 0x80900040.
    drive(1'b0, LH, 32'hFFFF_FFFE, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'hFFFF_8090) begin
      miscompares++; $display("FAIL lh_upper: got %h required ffff8090", dmem_data_out);
    end
    drive(1'b0, LHU, 32'hFFFF_FFFE, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'h0000_8090) begin
      miscompares++; $display("FAIL lhu_upper: got %h required 00008090", dmem_data_out);
    end
    drive(1'b1, LH, 32'hFFFF_FFFC, 32'h5555_1234);
    drive(1'b0, LW, 32'hFFFF_FFFC, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'h8090_1234) begin
      miscompares++; $display("FAIL sh_lower_lanes: got %h required 80901234", dmem_data_out);
    end
    $display("test_byte_half: done");
  endtask

  task automatic test_misaligned();
    drive(1'b1, LH, 32'hFFFF_FFFD, 32'h0000_BEEF);
    vectors++;
    if (misaligned !== 1'b1 || dmem_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL sh_misaligned: mis=%b data=%h required mis=1 data=00000000", misaligned, dmem_data_out);
    end
    drive(1'b0, LW, 32'hFFFF_FFFC, 32'h0);
    vectors++;
    if (misaligned !== 1'b0 || dmem_data_out !== 32'h8090_1234) begin
      miscompares++;
      $display("FAIL misaligned_pulse_and_word: mis=%b data=%h required mis=0 data=80901234", misaligned, dmem_data_out);
    end
    drive(1'b0, LW, 32'hFFFF_FFF6, 32'h0);
    vectors++;
    if (misaligned !== 1'b1 || dmem_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL lw_misaligned: mis=%b data=%h required mis=1 data=00000000", misaligned, dmem_data_out);
    end
    drive(1'b1, LW, 32'hFFFF_FFF8, 32'h0000_0005);
    vectors++;
    if (misaligned !== 1'b0) begin
      miscompares++; $display("FAIL store_readonly_mis: got %b required 0", misaligned);
    end
    drive(1'b1, BAD, 32'hFFFF_FFFC, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'h0) begin
      miscompares++; $display("FAIL undefined_funct3_read: got %h required 00000000", dmem_data_out);
    end
    drive(1'b0, LW, 32'hFFFF_FFFC, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'h8090_1234) begin
      miscompares++; $display("FAIL undefined_funct3_store: got %h required 80901234", dmem_data_out);
    end
    drive(1'b1, LW, 32'h0000_1000, 32'hDEAD_BEEF);
    vectors++;
    if (dmem_data_out !== 32'h0) begin
      miscompares++; $display("FAIL unmapped_read: got %h required 00000000", dmem_data_out);
    end
    $display("test_misaligned: done");
  endtask

  task automatic test_back_to_back();
    drive(1'b1, LW, 32'hFFFF_FFFC, 32'h1122_3344);
    vectors++;
    if (dmem_data_out !== 32'h8090_1234) begin
      miscompares++; $display("FAIL same_cycle_old: got %h required 80901234", dmem_data_out);
    end
    drive(1'b0, LW, 32'hFFFF_FFFC, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'h1122_3344) begin
      miscompares++; $display("FAIL same_cycle_new: got %h required 11223344", dmem_data_out);
    end
    $display("test_back_to_back: done");
  endtask

  task automatic test_reset_mid_pwm();
    drive(1'b1, LW, 32'hFFFF_FFFC, 32'h8080_8080);
    dmem_wren = 1'b0;
    repeat (37) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, LW, 32'hFFFF_FFFC, 32'h0);
    vectors++;
    if ({led, red, green, blue} !== 4'b0000 || dmem_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_pwm: pwm=%b data=%h required pwm=0000 data=00000000", {led, red, green, blue}, dmem_data_out);
    end
    drive(1'b0, LW, 32'hFFFF_FFFC, 32'h0);
    reset = 1'b0;
    drive(1'b0, LW, 32'hFFFF_FFF8, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'h0) begin
      miscompares++; $display("FAIL micros_after_reset: got %h required 00000000", dmem_data_out);
    end
    drive(1'b0, LW, 32'hFFFF_FFFC, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'h0) begin
      miscompares++; $display("FAIL duty_after_reset: got %h required 00000000", dmem_data_out);
    end
    $display("test_reset_mid_pwm: done");
  endtask

  task automatic test_timers();
    bit found;
    reset = 1'b1;
    drive(1'b0, LW, 32'hFFFF_FFF8, 32'h0);
    reset = 1'b0;
    // 12000 edges out of reset; the last edge captures the value before its own tick.
    for (int i = 0; i < 12000; i++) drive(1'b0, LW, 32'hFFFF_FFF8, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'd999) begin
      miscompares++; $display("FAIL micros_pre_increment: got %0d required 999", dmem_data_out);
    end
    drive(1'b0, LW, 32'hFFFF_FFF8, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'd1000) begin
      miscompares++; $display("FAIL micros_12000: got %0d required 1000", dmem_data_out);
    end
    drive(1'b0, LW, 32'hFFFF_FFF4, 32'h0);
    vectors++;
    if (dmem_data_out !== 32'd1) begin
      miscompares++; $display("FAIL millis_12000: got %0d required 1", dmem_data_out);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dut.us_pre_reg == 32'd11) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL micros_terminal_wait: got timeout required terminal count");
    end else begin
      force dut.micros_reg = 32'hFFFF_FFFF;
      #1;
      release dut.micros_reg;
      dmem_wren = 1'b0; funct3 = LW; dmem_address = 32'hFFFF_FFF8;
      @(posedge clk); #1;
      vectors++;
      if (dmem_data_out !== 32'hFFFF_FFFF) begin
        miscompares++; $display("FAIL micros_before_wrap: got %h required ffffffff", dmem_data_out);
      end
      drive(1'b0, LW, 32'hFFFF_FFF8, 32'h0);
      vectors++;
      if (dmem_data_out !== 32'h0) begin
        miscompares++; $display("FAIL micros_wrap: got %h required 00000000", dmem_data_out);
      end
    end
    $display("test_timers: done");
  endtask

  initial begin
    reset = 1'b1; dmem_wren = 1'b0; funct3 = LW;
    dmem_address = 32'h0; dmem_data_in = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_pwm();
    test_byte_half();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_pwm();
    test_timers();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
